// File: rtl/mem_pkg.sv
// Shared types and constants for the block-RAM access controller and its response FIFO.
// Holds the FSM encoding, the response word layout and the read-issue credit rule.
package mem_pkg;

    localparam int DATA_W         = 10;
    localparam int RSP_FIFO_DEPTH = 4;
    localparam int RSP_W          = DATA_W + 1;
    localparam int RSP_CNT_W      = $clog2(RSP_FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } rsp_t;

    // A new read may be issued only if every word already buffered or on the RAM
    // output, plus the one being issued, is guaranteed a FIFO slot.
    function automatic logic credit_ok(input logic [RSP_CNT_W-1:0] cnt,
                                       input logic                 v_data);
        return (int'(cnt) + int'(v_data)) < RSP_FIFO_DEPTH;
    endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Small synchronous FIFO for read responses; push-to-head visibility is one cycle.
// Pushes into a full FIFO and pops from an empty one are ignored; head reads 0 when empty.
module mem_rsp_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = RSP_FIFO_DEPTH,
    parameter int W     = RSP_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [W-1:0]                 push_dat_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 head_dat_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_access_ctrl.sv
// Block-RAM initiator: single-word writes (RAM strobe at T+1), burst reads (first word valid T+3).
// Read issue is credit-limited by the 4-entry response FIFO, so back-pressure stalls issue and never drops words.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int SIZE  = 6,
    parameter int DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [SIZE-1:0]   i_req_addr,
    input  logic [SIZE-1:0]   i_req_len,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_last,
    output logic              o_ram_we,
    output logic [SIZE-1:0]   o_ram_addr,
    output logic [DATA_W-1:0] o_ram_data_in,
    input  logic [DATA_W-1:0] i_ram_data_out
);

    localparam logic [SIZE-1:0] ADDR_LAST = SIZE'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [SIZE-1:0]     addr_ctr_q, addr_ctr_d;
    logic [SIZE-1:0]     remaining_q, remaining_d;
    logic [SIZE-1:0]     ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_data_in_q, ram_data_in_d;
    logic                ram_we_q, ram_we_d;
    logic                v_data_q, v_data_d;
    logic                last_data_q, last_data_d;

    logic                req_ready;
    logic                req_fire;
    logic                credit;
    logic                issue;
    logic                issue_last;
    logic                rsp_pop;
    logic                fifo_empty;
    logic [RSP_CNT_W-1:0] fifo_count;
    rsp_t                push_rsp;
    rsp_t                head_rsp;

    assign req_ready = (state_q == IDLE) && rst;
    assign req_fire  = i_req_valid && req_ready;
    assign credit    = credit_ok(fifo_count, v_data_q);

    always_comb begin
        state_d       = state_q;
        addr_ctr_d    = addr_ctr_q;
        remaining_d   = remaining_q;
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;
        ram_we_d      = 1'b0;
        issue         = 1'b0;
        issue_last    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    if (i_req_we) begin
                        ram_we_d      = 1'b1;
                        ram_addr_d    = i_req_addr;
                        ram_data_in_d = i_req_wdata;
                        state_d       = WRITE;
                    end else begin
                        addr_ctr_d  = i_req_addr;
                        remaining_d = i_req_len;
                        state_d     = READ;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            READ: begin
                // The address is presented combinationally in the issue cycle so the
                // RAM's registered output lines up with the data stage one cycle later.
                if (credit) begin
                    issue      = 1'b1;
                    ram_addr_d = addr_ctr_q;
                    addr_ctr_d = (addr_ctr_q == ADDR_LAST) ? '0 : addr_ctr_q + 1'b1;
                    if (remaining_q == '0) begin
                        issue_last = 1'b1;
                        state_d    = DRAIN;
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty && !v_data_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        v_data_d    = issue;
        last_data_d = issue_last;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            addr_ctr_q    <= '0;
            remaining_q   <= '0;
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
            ram_we_q      <= 1'b0;
            v_data_q      <= 1'b0;
            last_data_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_ctr_q    <= addr_ctr_d;
            remaining_q   <= remaining_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
            ram_we_q      <= ram_we_d;
            v_data_q      <= v_data_d;
            last_data_q   <= last_data_d;
        end
    end

    assign push_rsp = '{last: last_data_q, data: i_ram_data_out};
    assign rsp_pop  = o_rsp_valid && i_rsp_ready;

    mem_rsp_fifo #(
        .DEPTH (RSP_FIFO_DEPTH),
        .W     (RSP_W)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (v_data_q),
        .push_dat_i (push_rsp),
        .pop_i      (rsp_pop),
        .head_dat_o (head_rsp),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty)
    );

    assign o_req_ready   = req_ready;
    assign o_rsp_valid   = !fifo_empty;
    assign o_rsp_data    = head_rsp.data;
    assign o_rsp_last    = head_rsp.last;
    assign o_ram_we      = ram_we_q;
    assign o_ram_addr    = issue ? addr_ctr_q : ram_addr_q;
    assign o_ram_data_in = ram_data_in_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural one-cycle-latency RAM attached.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_req_valid;
    logic       o_req_ready;
    logic       i_req_we;
    logic [5:0] i_req_addr;
    logic [5:0] i_req_len;
    logic [9:0] i_req_wdata;
    logic       o_rsp_valid;
    logic       i_rsp_ready;
    logic [9:0] o_rsp_data;
    logic       o_rsp_last;
    logic       o_ram_we;
    logic [5:0] o_ram_addr;
    logic [9:0] o_ram_data_in;
    logic [9:0] i_ram_data_out;

    logic [9:0] ram [64];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_ram_we) ram[o_ram_addr] <= o_ram_data_in;
        i_ram_data_out <= ram[o_ram_addr];
    end

    mem_access_ctrl #(.SIZE(6), .DEPTH(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_addr     (i_req_addr),
        .i_req_len      (i_req_len),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_data     (o_rsp_data),
        .o_rsp_last     (o_rsp_last),
        .o_ram_we       (o_ram_we),
        .o_ram_addr     (o_ram_addr),
        .o_ram_data_in  (o_ram_data_in),
        .i_ram_data_out (i_ram_data_out)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [9:0] d);
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_addr  = a;
        i_req_wdata = d;
        #1;
        for (int i = 0; i < 30 && o_req_ready !== 1'b1; i++) cyc();
        tests++;
        if (o_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL wr_ready_wait: o_req_ready=%0b required 1", o_req_ready);
        end
        cyc();
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        cyc();
    endtask

    // Returns one cycle after the accept edge (cycle R+1).
    task automatic start_read(input logic [5:0] a, input logic [5:0] len);
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_addr  = a;
        i_req_len   = len;
        #1;
        for (int i = 0; i < 30 && o_req_ready !== 1'b1; i++) cyc();
        tests++;
        if (o_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL rd_ready_wait: o_req_ready=%0b required 1", o_req_ready);
        end
        cyc();
        i_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0;
        i_req_len = '0; i_req_wdata = '0; i_rsp_ready = 1'b0;
        cyc();
        cyc();
        tests++; if (o_ram_we !== 1'b0) begin fails++; $display("FAIL rst_ram_we: got %0b required 0", o_ram_we); end
        tests++; if (o_ram_addr !== 6'd0) begin fails++; $display("FAIL rst_ram_addr: got %0d required 0", o_ram_addr); end
        tests++; if (o_ram_data_in !== 10'd0) begin fails++; $display("FAIL rst_ram_data_in: got %0h required 0", o_ram_data_in); end
        tests++; if (o_rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %0b required 0", o_rsp_valid); end
        tests++; if (o_rsp_data !== 10'd0) begin fails++; $display("FAIL rst_rsp_data: got %0h required 0", o_rsp_data); end
        tests++; if (o_rsp_last !== 1'b0) begin fails++; $display("FAIL rst_rsp_last: got %0b required 0", o_rsp_last); end
        tests++; if (o_req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready_low: got %0b required 0", o_req_ready); end
        rst = 1'b1;
        #1;
        tests++; if (o_req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready_high: got %0b required 1", o_req_ready); end
    endtask

    task automatic test_write_read();
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 6'd5; i_req_wdata = 10'h2A5;
        #1;
        tests++; if (o_req_ready !== 1'b1) begin fails++; $display("FAIL wr_accept_ready: got %0b required 1", o_req_ready); end
        cyc();
        i_req_valid = 1'b0; i_req_we = 1'b0;
        tests++; if (o_ram_we !== 1'b1) begin fails++; $display("FAIL wr_we_t1: got %0b required 1", o_ram_we); end
        tests++; if (o_ram_addr !== 6'd5) begin fails++; $display("FAIL wr_addr_t1: got %0d required 5", o_ram_addr); end
        tests++; if (o_ram_data_in !== 10'h2A5) begin fails++; $display("FAIL wr_data_t1: got %0h required 2a5", o_ram_data_in); end
        tests++; if (o_req_ready !== 1'b0) begin fails++; $display("FAIL wr_ready_t1: got %0b required 0", o_req_ready); end
        cyc();
        tests++; if (o_ram_we !== 1'b0) begin fails++; $display("FAIL wr_we_t2: got %0b required 0", o_ram_we); end
        tests++; if (o_req_ready !== 1'b1) begin fails++; $display("FAIL wr_ready_t2: got %0b required 1", o_req_ready); end
        i_rsp_ready = 1'b1;
        start_read(6'd5, 6'd0);
        tests++; if (o_ram_addr !== 6'd5) begin fails++; $display("FAIL rd_addr_r1: got %0d required 5", o_ram_addr); end
        tests++; if (o_rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_r1: got %0b required 0", o_rsp_valid); end
        cyc();
        tests++; if (o_rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_r2: got %0b required 0", o_rsp_valid); end
        cyc();
        tests++;
        if ({o_rsp_valid, o_rsp_data, o_rsp_last} !== {1'b1, 10'h2A5, 1'b1}) begin
            fails++;
            $display("FAIL rd_rsp_r3: valid=%0b data=%0h last=%0b required 1/2a5/1", o_rsp_valid, o_rsp_data, o_rsp_last);
        end
        cyc();
        tests++; if (o_rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_r4: got %0b required 0", o_rsp_valid); end
    endtask

    task automatic test_burst();
        do_write(6'd10, 10'd1);
        do_write(6'd11, 10'd2);
        do_write(6'd12, 10'd3);
        do_write(6'd13, 10'd4);
        i_rsp_ready = 1'b1;
        start_read(6'd10, 6'd3);
        cyc();
        cyc();
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({o_rsp_valid, o_rsp_data, o_rsp_last} !== {1'b1, 10'(k + 1), (k == 3)}) begin
                fails++;
                $display("FAIL burst_word%0d: valid=%0b data=%0d last=%0b required 1/%0d/%0b",
                         k, o_rsp_valid, o_rsp_data, o_rsp_last, k + 1, (k == 3));
            end
            cyc();
        end
        tests++; if (o_rsp_valid !== 1'b0) begin fails++; $display("FAIL burst_end_valid: got %0b required 0", o_rsp_valid); end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_w [4];
        exp_w = '{10'h3E0, 10'h3F1, 10'h002, 10'h013};
        do_write(6'd62, exp_w[0]);
        do_write(6'd63, exp_w[1]);
        do_write(6'd0,  exp_w[2]);
        do_write(6'd1,  exp_w[3]);
        i_rsp_ready = 1'b1;
        start_read(6'd62, 6'd3);
        cyc();
        cyc();
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({o_rsp_valid, o_rsp_data, o_rsp_last} !== {1'b1, exp_w[k], (k == 3)}) begin
                fails++;
                $display("FAIL wrap_word%0d: valid=%0b data=%0h last=%0b required 1/%0h/%0b",
                         k, o_rsp_valid, o_rsp_data, o_rsp_last, exp_w[k], (k == 3));
            end
            cyc();
        end
        tests++; if (o_rsp_valid !== 1'b0) begin fails++; $display("FAIL wrap_end_valid: got %0b required 0", o_rsp_valid); end
    endtask

    task automatic test_backpressure();
        i_rsp_ready = 1'b0;
        start_read(6'd10, 6'd3);
        cyc();
        cyc();
        for (int s = 0; s < 6; s++) begin
            tests++;
            if ({o_rsp_valid, o_rsp_data, o_rsp_last} !== {1'b1, 10'd1, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold%0d: valid=%0b data=%0d last=%0b required 1/1/0",
                         s, o_rsp_valid, o_rsp_data, o_rsp_last);
            end
            cyc();
        end
        tests++; if (dut.fifo_count !== 3'd4) begin fails++; $display("FAIL bp_buffered: got %0d required 4", dut.fifo_count); end
        i_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({o_rsp_valid, o_rsp_data, o_rsp_last} !== {1'b1, 10'(k + 1), (k == 3)}) begin
                fails++;
                $display("FAIL bp_word%0d: valid=%0b data=%0d last=%0b required 1/%0d/%0b",
                         k, o_rsp_valid, o_rsp_data, o_rsp_last, k + 1, (k == 3));
            end
            cyc();
        end
        tests++; if (o_rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_end_valid: got %0b required 0", o_rsp_valid); end
    endtask

    task automatic test_write_during_drain();
        logic [9:0] exp_w [4];
        int         k;
        logic       accepted;
        exp_w    = '{10'd1, 10'd2, 10'd3, 10'd4};
        k        = 0;
        accepted = 1'b0;
        i_rsp_ready = 1'b0;
        start_read(6'd10, 6'd3);
        for (int i = 0; i < 4; i++) cyc();
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 6'd40; i_req_wdata = 10'h1C3;
        #1;
        for (int s = 0; s < 4; s++) begin
            tests++;
            if ({o_req_ready, o_ram_we} !== 2'b00) begin
                fails++;
                $display("FAIL drain_block%0d: ready=%0b we=%0b required 0/0", s, o_req_ready, o_ram_we);
            end
            cyc();
        end
        i_rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (o_rsp_valid === 1'b1) begin
                tests++;
                if (k > 3 || {o_rsp_data, o_rsp_last} !== {exp_w[k[1:0]], (k == 3)}) begin
                    fails++;
                    $display("FAIL drain_word%0d: data=%0d last=%0b required %0d/%0b",
                             k, o_rsp_data, o_rsp_last, exp_w[k[1:0]], (k == 3));
                end
                k++;
            end
            if (o_req_ready === 1'b1) begin
                accepted = 1'b1;
                cyc();
                break;
            end
            cyc();
        end
        i_req_valid = 1'b0; i_req_we = 1'b0;
        tests++; if (accepted !== 1'b1) begin fails++; $display("FAIL drain_wr_accept: got %0b required 1", accepted); end
        tests++; if (k != 4) begin fails++; $display("FAIL drain_word_count: got %0d required 4", k); end
        tests++;
        if ({o_ram_we, o_ram_addr, o_ram_data_in} !== {1'b1, 6'd40, 10'h1C3}) begin
            fails++;
            $display("FAIL drain_wr_strobe: we=%0b addr=%0d data=%0h required 1/40/1c3", o_ram_we, o_ram_addr, o_ram_data_in);
        end
        cyc();
        start_read(6'd40, 6'd0);
        cyc();
        cyc();
        tests++;
        if ({o_rsp_valid, o_rsp_data, o_rsp_last} !== {1'b1, 10'h1C3, 1'b1}) begin
            fails++;
            $display("FAIL drain_readback: valid=%0b data=%0h last=%0b required 1/1c3/1", o_rsp_valid, o_rsp_data, o_rsp_last);
        end
        cyc();
    endtask

    task automatic test_reset_midburst();
        logic seen;
        seen = 1'b0;
        i_rsp_ready = 1'b1;
        start_read(6'd20, 6'd7);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        tests++; if (o_req_ready !== 1'b0) begin fails++; $display("FAIL mrst_ready_low: got %0b required 0", o_req_ready); end
        cyc();
        tests++;
        if ({o_rsp_valid, o_ram_we, o_rsp_data, o_rsp_last} !== {1'b0, 1'b0, 10'd0, 1'b0}) begin
            fails++;
            $display("FAIL mrst_flush: valid=%0b we=%0b data=%0h last=%0b required 0/0/0/0", o_rsp_valid, o_ram_we, o_rsp_data, o_rsp_last);
        end
        rst = 1'b1;
        #1;
        tests++; if (o_req_ready !== 1'b1) begin fails++; $display("FAIL mrst_ready_high: got %0b required 1", o_req_ready); end
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (o_rsp_valid !== 1'b0) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL mrst_no_rsp: response seen=%0b required 0", seen); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_burst();
        test_wrap();
        test_backpressure();
        test_write_during_drain();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
